// File: rtl/io_pkg.sv
// Shared widths and defaults for the board I/O path (switch reader, LED driver, UART TX),
// plus the output-stage action decode used by the switch bank reader.
package io_pkg;

    localparam int IO_DATA_W          = 8;
    localparam int SW_SYNC_STAGES     = 2;
    localparam int SW_DEBOUNCE_CYCLES = 50000;

    typedef enum logic [2:0] {
        OUT_HOLD,
        OUT_LOAD,
        OUT_PARK,
        OUT_PARK_OVR,
        OUT_POP,
        OUT_DRAIN,
        OUT_BYPASS,
        OUT_BYPASS_OVR
    } out_action_e;

    // What the one-deep output stage does this edge, given handshake, event and slot state.
    function automatic out_action_e out_action(input logic valid, input logic xfer,
                                               input logic ev, input logic pend);
        if (!valid)
            return ev ? OUT_LOAD : OUT_HOLD;
        if (!xfer) begin
            if (!ev)
                return OUT_HOLD;
            return pend ? OUT_PARK_OVR : OUT_PARK;
        end
        if (!ev)
            return pend ? OUT_POP : OUT_DRAIN;
        return pend ? OUT_BYPASS_OVR : OUT_BYPASS;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Per-bit multi-flop synchroniser for asynchronous inputs; Dout is the last stage.
module bit_synchronizer #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge
    // value of its neighbour; blocking here would collapse the chain into a single flop.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN)
            chain <= '0;
        else
            chain <= {chain[STAGES-2:0], Din};
    end

    assign Dout = chain[STAGES-1];

endmodule

// File: rtl/switch_bank_reader.sv
// Synchronises and debounces an 8-bit switch bank and emits each newly committed value
// once on a valid/ready byte interface, with a one-deep pending slot and sticky overrun.
module switch_bank_reader
    import io_pkg::*;
#(
    parameter int DATA_W          = IO_DATA_W,
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic [DATA_W-1:0] SwIn,
    input  logic              En,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    input  logic              DataReady,
    output logic              Overrun
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DATA_W-1:0] sync;
    logic [DATA_W-1:0] cand;
    logic [DATA_W-1:0] debounced;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] pend_data;
    logic              pend_flag;
    logic              ev;
    logic              xfer;
    out_action_e       action;

    bit_synchronizer #(
        .WIDTH  (DATA_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk  (Clk),
        .RstN (RstN),
        .Din  (SwIn),
        .Dout (sync)
    );

    // A commit edge only raises an event when the held value differs from the last commit.
    assign ev     = (sync == cand) && En && (cnt == CNT_LAST) && (cand != debounced);
    assign xfer   = DataValid && DataReady;
    assign action = out_action(DataValid, xfer, ev, pend_flag);

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            cand      <= '0;
            debounced <= '0;
            cnt       <= '0;
        end else if (sync != cand) begin
            cand <= sync;
            cnt  <= '0;
        end else if (!En) begin
            cnt <= '0;
        end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end else if (ev) begin
            debounced <= cand;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            DataOut   <= '0;
            DataValid <= 1'b0;
            pend_data <= '0;
            pend_flag <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            case (action)
                OUT_LOAD: begin
                    DataOut   <= cand;
                    DataValid <= 1'b1;
                end
                OUT_PARK: begin
                    pend_data <= cand;
                    pend_flag <= 1'b1;
                end
                OUT_PARK_OVR: begin
                    pend_data <= cand;
                    Overrun   <= 1'b1;
                end
                OUT_POP: begin
                    DataOut   <= pend_data;
                    pend_flag <= 1'b0;
                end
                OUT_DRAIN: begin
                    DataValid <= 1'b0;
                end
                OUT_BYPASS: begin
                    DataOut <= cand;
                end
                // Newest value wins; the parked byte is discarded.
                OUT_BYPASS_OVR: begin
                    DataOut   <= cand;
                    pend_flag <= 1'b0;
                    Overrun   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
